spi_shift_master: RTL and testbench

- SPI mode-0 master running entirely in the 48 MHz `clk` domain.
- Consumes the free-running divided square wave `spiClock` from the clock controller (period 512 clk). Uses its edges as shift strobes rather than as a clock.
- Serialises words accepted over a valid/ready interface onto `sclk`/`mosi`/`cs_n` and returns the word captured from `miso`.
- Sits between the clock controller and peripheral drivers (display, flash).

---
 rtl/spi_shift_master.sv | 121 ++++++++++++
 tb/tb_spi_shift_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_master.sv
// spi_shift_master: SPI mode-0 master clocked by clk, using the edges
// of the divided spi_clk_in square wave as shift strobes.
module spi_shift_master #(
    parameter int DATA_WIDTH    = 8,
    parameter int CS_HOLD_EDGES = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  spi_clk_in,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_last,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SHIFT,
        NEXT,
        HOLD
    } stateT;

    stateT state, stateNext;

    logic                  sQ;
    logic                  rise;
    logic                  fall;
    logic                  txFire;
    logic                  lastQ;
    logic [CW-1:0]         cnt;
    logic [3:0]            holdCnt;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] rxShift;

    assign rise     = spi_clk_in & ~sQ;
    assign fall     = ~spi_clk_in & sQ;
    assign tx_ready = (state == IDLE) || (state == NEXT);
    assign busy     = (state != IDLE);
    assign txFire   = tx_valid & tx_ready;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (txFire) stateNext = ALIGN;
            ALIGN:   if (fall) stateNext = SHIFT;
            SHIFT: begin
                if (fall && cnt == '0)
                    stateNext = lastQ ? HOLD : NEXT;
            end
            NEXT:    if (txFire) stateNext = ALIGN;
            HOLD:    if (holdCnt == '0) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sQ       <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            lastQ    <= 1'b0;
            cnt      <= '0;
            holdCnt  <= '0;
            shiftReg <= '0;
            rxShift  <= '0;
        end else begin
            sQ       <= spi_clk_in;
            // sclk lags spi_clk_in by one clk so it moves with mosi
            sclk     <= (state == SHIFT) & spi_clk_in;
            rx_valid <= 1'b0;
            if (txFire) begin
                shiftReg <= tx_data;
                lastQ    <= tx_last;
                cnt      <= CW'(DATA_WIDTH);
                cs_n     <= 1'b0;
                mosi     <= tx_data[DATA_WIDTH-1];
            end
            if (state == SHIFT) begin
                if (rise) begin
                    rxShift <= {rxShift[DATA_WIDTH-2:0], miso};
                    cnt     <= cnt - 1'b1;
                end
                if (fall) begin
                    if (cnt != '0) begin
                        shiftReg <= shiftReg << 1;
                        mosi     <= shiftReg[DATA_WIDTH-2];
                    end else begin
                        rx_data  <= rxShift;
                        rx_valid <= 1'b1;
                        holdCnt  <= 4'(CS_HOLD_EDGES);
                    end
                end
            end
            if (state == HOLD) begin
                if (holdCnt == '0)
                    cs_n <= 1'b1;
                else if (fall)
                    holdCnt <= holdCnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_master.sv
// tb_spi_shift_master: directed bench for an 8-bit/hold-1 instance and
// a 16-bit/hold-0 instance sharing one divided spi clock.
module tb_spi_shift_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic spiClk = 1'b0;
    int   halfPer = 4;
    int   divCnt = 0;

    always @(posedge clk) begin
        if (divCnt >= halfPer - 1) begin
            divCnt <= 0;
            spiClk <= ~spiClk;
        end else begin
            divCnt <= divCnt + 1;
        end
    end

    int misoMode = 0;

    logic [7:0]  txData0;
    logic        txLast0, txValid0, txReady0, miso0;
    logic        sclk0, mosi0, csN0, rxValid0, busy0;
    logic [7:0]  rxData0;
    logic [15:0] txData1;
    logic        txLast1, txValid1, txReady1, miso1;
    logic        sclk1, mosi1, csN1, rxValid1, busy1;
    logic [15:0] rxData1;

    assign miso0 = (misoMode == 0) ? mosi0 :
                   (misoMode == 1) ? 1'b1 : ~mosi0;
    assign miso1 = (misoMode == 0) ? mosi1 :
                   (misoMode == 1) ? 1'b1 : ~mosi1;

    spi_shift_master #(.DATA_WIDTH(8), .CS_HOLD_EDGES(1)) u8 (
        .clk(clk), .resetn(resetn), .spi_clk_in(spiClk),
        .tx_data(txData0), .tx_last(txLast0), .tx_valid(txValid0),
        .tx_ready(txReady0), .miso(miso0), .sclk(sclk0),
        .mosi(mosi0), .cs_n(csN0), .rx_data(rxData0),
        .rx_valid(rxValid0), .busy(busy0)
    );

    spi_shift_master #(.DATA_WIDTH(16), .CS_HOLD_EDGES(0)) u16 (
        .clk(clk), .resetn(resetn), .spi_clk_in(spiClk),
        .tx_data(txData1), .tx_last(txLast1), .tx_valid(txValid1),
        .tx_ready(txReady1), .miso(miso1), .sclk(sclk1),
        .mosi(mosi1), .cs_n(csN1), .rx_data(rxData1),
        .rx_valid(rxValid1), .busy(busy1)
    );

    logic        sclkV[2], mosiV[2], csV[2], rvV[2], rdyV[2], busyV[2];
    logic [31:0] rdV[2];
    assign sclkV[0] = sclk0;    assign sclkV[1] = sclk1;
    assign mosiV[0] = mosi0;    assign mosiV[1] = mosi1;
    assign csV[0]   = csN0;     assign csV[1]   = csN1;
    assign rvV[0]   = rxValid0; assign rvV[1]   = rxValid1;
    assign rdyV[0]  = txReady0; assign rdyV[1]  = txReady1;
    assign busyV[0] = busy0;    assign busyV[1] = busy1;
    assign rdV[0]   = {24'h0, rxData0};
    assign rdV[1]   = {16'h0, rxData1};

    int          cyc = 0;
    int          rises[2] = '{0, 0};
    int          csRises[2] = '{0, 0};
    int          csFalls[2] = '{0, 0};
    int          rxCount[2] = '{0, 0};
    int          rxDouble[2] = '{0, 0};
    int          sclkRiseCyc[2] = '{0, 0};
    int          sclkFallCyc[2] = '{0, 0};
    int          sclkHigh[2] = '{0, 0};
    int          csFallCyc[2] = '{0, 0};
    int          csRiseCyc[2] = '{0, 0};
    int          csLowLen[2] = '{0, 0};
    logic [63:0] mosiBits[2] = '{64'h0, 64'h0};
    logic [31:0] rxLast[2] = '{32'h0, 32'h0};
    logic [31:0] rxPrev[2] = '{32'h0, 32'h0};
    logic        pS[2] = '{1'b0, 1'b0};
    logic        pC[2] = '{1'b1, 1'b1};
    logic        pR[2] = '{1'b0, 1'b0};

    // Observers: everything sampled on the falling clk edge
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (sclkV[k] && !pS[k]) begin
                rises[k]++;
                mosiBits[k] = {mosiBits[k][62:0], mosiV[k]};
                sclkRiseCyc[k] = cyc;
            end
            if (!sclkV[k] && pS[k]) begin
                sclkFallCyc[k] = cyc;
                sclkHigh[k] = cyc - sclkRiseCyc[k];
            end
            if (!csV[k] && pC[k]) begin
                csFalls[k]++;
                csFallCyc[k] = cyc;
            end
            if (csV[k] && !pC[k]) begin
                csRises[k]++;
                csRiseCyc[k] = cyc;
                csLowLen[k] = cyc - csFallCyc[k];
            end
            if (rvV[k]) begin
                rxCount[k]++;
                rxPrev[k] = rxLast[k];
                rxLast[k] = rdV[k];
                if (pR[k]) rxDouble[k]++;
            end
            pS[k] = sclkV[k];
            pC[k] = csV[k];
            pR[k] = rvV[k];
        end
    end

    int nCmp = 0;
    int nFail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int k, input logic [31:0] d,
                        input logic last);
        int n = 0;
        if (k == 0) begin
            txData0 = d[7:0]; txLast0 = last; txValid0 = 1'b1;
        end else begin
            txData1 = d[15:0]; txLast1 = last; txValid1 = 1'b1;
        end
        while (!rdyV[k] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 64'(rdyV[k]), 64'd1);
        @(negedge clk);
        if (k == 0) txValid0 = 1'b0;
        else        txValid1 = 1'b0;
    endtask

    task automatic waitRx(input int k, input int target, input int budget);
        int n = 0;
        while (rxCount[k] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("rx_timeout", 64'(rxCount[k] >= target), 64'd1);
    endtask

    task automatic waitIdle(input int k, input int budget);
        int n = 0;
        while (busyV[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busyV[k]), 64'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int rb, rc, cr, cf, n;

    initial begin
        resetn = 1'b0;
        txData0 = '0; txLast0 = 1'b0; txValid0 = 1'b0;
        txData1 = '0; txLast1 = 1'b0; txValid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_csn", 64'(csN0), 64'd1);
        chk("rst_sclk", 64'(sclk0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_ready", 64'(txReady0), 64'd1);
        chk("rst_rxdata", 64'(rxData0), 64'd0);
        chk("rst_rxvalid", 64'(rxValid0), 64'd0);
        chk("rst_csn16", 64'(csN1), 64'd1);
        resetn = 1'b1;
        @(negedge clk);

        // abort a word after three sclk rises
        misoMode = 0;
        rc = rxCount[0];
        rb = rises[0];
        send(0, 32'h96, 1'b1);
        n = 0;
        while (rises[0] - rb < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_rises", 64'(rises[0] - rb), 64'd3);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_csn", 64'(csN0), 64'd1);
        chk("abort_sclk", 64'(sclk0), 64'd0);
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_ready", 64'(txReady0), 64'd1);
        repeat (40) @(negedge clk);
        chk("abort_no_rxv", 64'(rxCount[0] - rc), 64'd0);
        rb = rises[0];
        send(0, 32'h3C, 1'b1);
        waitRx(0, rc + 1, 500);
        waitIdle(0, 500);
        chk("post_rx", 64'(rxLast[0]), 64'h3C);
        chk("post_mosi", mosiBits[0] & 64'hFF, 64'h3C);
        chk("post_rises", 64'(rises[0] - rb), 64'd8);

        // single word, loopback
        rc = rxCount[0];
        rb = rises[0];
        send(0, 32'hA5, 1'b1);
        waitRx(0, rc + 1, 500);
        waitIdle(0, 500);
        chk("a5_rises", 64'(rises[0] - rb), 64'd8);
        chk("a5_mosi", mosiBits[0] & 64'hFF, 64'hA5);
        chk("a5_rx", 64'(rxLast[0]), 64'hA5);
        chk("a5_rxcnt", 64'(rxCount[0] - rc), 64'd1);
        chk("a5_pulse", 64'(rxDouble[0]), 64'd0);
        chk("a5_hold", 64'(csRiseCyc[0] - sclkFallCyc[0]), 64'd9);
        chk("a5_high", 64'(sclkHigh[0]), 64'd4);

        // two back-to-back words, miso tied high
        misoMode = 1;
        rc = rxCount[0];
        rb = rises[0];
        cr = csRises[0];
        cf = csFalls[0];
        send(0, 32'h12, 1'b0);
        send(0, 32'hF0, 1'b1);
        waitRx(0, rc + 2, 1000);
        waitIdle(0, 500);
        chk("two_csrise", 64'(csRises[0] - cr), 64'd1);
        chk("two_csfall", 64'(csFalls[0] - cf), 64'd1);
        chk("two_rxcnt", 64'(rxCount[0] - rc), 64'd2);
        chk("two_rx1", 64'(rxPrev[0]), 64'hFF);
        chk("two_rx2", 64'(rxLast[0]), 64'hFF);
        chk("two_rises", 64'(rises[0] - rb), 64'd16);
        chk("two_mosi", mosiBits[0] & 64'hFFFF, 64'h12F0);
        chk("two_pulse", 64'(rxDouble[0]), 64'd0);

        // word offered while shifting is held off until NEXT
        misoMode = 0;
        rc = rxCount[0];
        send(0, 32'h81, 1'b0);
        rb = rises[0];
        n = 0;
        while (rises[0] - rb < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        txData0 = 8'h5A; txLast0 = 1'b1; txValid0 = 1'b1;
        chk("shift_ready", 64'(txReady0), 64'd0);
        n = 0;
        while (!txReady0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("next_ready", 64'(txReady0), 64'd1);
        chk("next_rises", 64'(rises[0] - rb), 64'd8);
        chk("next_busy", 64'(busy0), 64'd1);
        chk("next_csn", 64'(csN0), 64'd0);
        @(negedge clk);
        txValid0 = 1'b0;
        chk("taken_ready", 64'(txReady0), 64'd0);
        waitRx(0, rc + 2, 500);
        waitIdle(0, 500);
        chk("held_rx1", 64'(rxPrev[0]), 64'h81);
        chk("held_rx2", 64'(rxLast[0]), 64'h5A);
        chk("held_mosi", mosiBits[0] & 64'hFFFF, 64'h815A);

        // 16-bit instance, no hold edges, inverted loopback
        misoMode = 2;
        rc = rxCount[1];
        rb = rises[1];
        send(1, 32'h8001, 1'b1);
        waitRx(1, rc + 1, 1000);
        waitIdle(1, 500);
        chk("w16_rx", 64'(rxLast[1]), 64'h7FFE);
        chk("w16_mosi", mosiBits[1] & 64'hFFFF, 64'h8001);
        chk("w16_rises", 64'(rises[1] - rb), 64'd16);
        chk("w16_hold", 64'(csRiseCyc[1] - sclkFallCyc[1]), 64'd1);

        // full-rate 512-clk spi clock
        misoMode = 0;
        halfPer = 256;
        n = 0;
        while (spiClk && n < 2000) begin @(negedge clk); n++; end
        while (!spiClk && n < 2000) begin @(negedge clk); n++; end
        rc = rxCount[0];
        send(0, 32'hC3, 1'b1);
        waitRx(0, rc + 1, 6000);
        waitIdle(0, 2000);
        chk("slow_rx", 64'(rxLast[0]), 64'hC3);
        chk("slow_high", 64'(sclkHigh[0]), 64'd256);
        chk("slow_cs_max", 64'(csLowLen[0] <= 5120), 64'd1);
        chk("slow_cs_min", 64'(csLowLen[0] >= 4096), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nFail);
        $finish;
    end

endmodule
